// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_TAG,
        ST_SEND_DATA,
        ST_WAIT_HI,
        ST_WAIT_LO
    } arb_state_t;

    localparam logic [3:0] TAG_NIBBLE = 4'hA;
    localparam int         GRANT_W    = 2;

    function automatic logic [7:0] make_tag(input logic [GRANT_W-1:0] id);
        return {TAG_NIBBLE, 2'b00, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin selector starting after last_grant
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [N_REQ-1:0]   grant,
    output logic [GRANT_W-1:0] grant_idx,
    output logic               grant_valid
);

    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        // Offsets 1..N_REQ visit last_grant itself last, so it only wins when alone.
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(last_grant) + off) % N_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = GRANT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding tagged byte frames to one UART transmitter
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int TAG_EN       = 1,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int               CNT_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT);

    arb_state_t         state, state_nxt;
    logic [GRANT_W-1:0] grant_q;
    logic [GRANT_W-1:0] last_grant;
    logic [7:0]         data_q;
    logic [7:0]         tx_data_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               tag_phase;
    logic               err_q;

    logic [N_REQ-1:0]   arb_grant;
    logic [GRANT_W-1:0] arb_idx;
    logic               arb_valid;
    logic [7:0]         sel_byte;

    logic               accept;
    logic               timeout;
    logic               frame_done;
    logic               tag_done;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr (
        .req         (req_valid),
        .last_grant  (last_grant),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign sel_byte = req_data[8*arb_idx +: 8];
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        tx_start   = 1'b0;
        accept     = 1'b0;
        timeout    = 1'b0;
        frame_done = 1'b0;
        tag_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    req_ready = arb_grant;
                    accept    = 1'b1;
                    state_nxt = (TAG_EN != 0) ? ST_SEND_TAG : ST_SEND_DATA;
                end
            end
            ST_SEND_TAG, ST_SEND_DATA: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_LO;
                end else if (cnt_inc == CNT_MAX) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (tag_phase) begin
                        tag_done  = 1'b1;
                        state_nxt = ST_SEND_DATA;
                    end else begin
                        frame_done = 1'b1;
                        state_nxt  = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            last_grant <= GRANT_W'(N_REQ - 1);
            data_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            cnt        <= '0;
            tag_phase  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant_q   <= arb_idx;
                data_q    <= sel_byte;
                tag_phase <= (TAG_EN != 0);
                tx_data_q <= (TAG_EN != 0) ? make_tag(arb_idx) : sel_byte;
            end
            if (tx_start) begin
                cnt <= '0;
            end else if (state == ST_WAIT_HI) begin
                cnt <= cnt_inc;
            end
            if (tag_done) begin
                tag_phase <= 1'b0;
                tx_data_q <= data_q;
            end
            // A timed-out frame still advances the rotation so a dead requester cannot starve others.
            if (timeout) begin
                err_q      <= 1'b1;
                last_grant <= grant_q;
            end
            if (frame_done) begin
                last_grant <= grant_q;
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign busy        = (state != ST_IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed table and sequence bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic        man_busy = 1'b0;
    logic        model_busy = 1'b0;
    logic        auto_tx = 1'b0;
    logic        sel_nt = 1'b0;
    logic        tx_busy;

    logic [3:0]  a_ready, b_ready;
    logic        a_start, b_start;
    logic [7:0]  a_data, b_data;
    logic [1:0]  a_grant, b_grant;
    logic        a_busy, b_busy;
    logic        a_err, b_err;

    logic [3:0]  mon_ready;
    logic        mon_start;
    logic [7:0]  mon_data;
    logic [1:0]  mon_grant;
    logic        mon_busy;
    logic        mon_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  tx_log[$];
    logic [3:0]  rdy_log[$];
    int          busy_cnt = 0;
    logic        started = 1'b0;

    always #5 clk = ~clk;

    assign tx_busy   = auto_tx ? model_busy : man_busy;
    assign mon_ready = sel_nt ? b_ready : a_ready;
    assign mon_start = sel_nt ? b_start : a_start;
    assign mon_data  = sel_nt ? b_data  : a_data;
    assign mon_grant = sel_nt ? b_grant : a_grant;
    assign mon_busy  = sel_nt ? b_busy  : a_busy;
    assign mon_err   = sel_nt ? b_err   : a_err;

    uart_tx_arbiter #(.N_REQ(4), .TAG_EN(1), .BUSY_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(a_ready), .tx_start(a_start), .tx_data(a_data), .tx_busy(tx_busy),
        .grant_id(a_grant), .busy(a_busy), .err_timeout(a_err)
    );

    uart_tx_arbiter #(.N_REQ(4), .TAG_EN(0), .BUSY_TIMEOUT(16)) dut_nt (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(b_ready), .tx_start(b_start), .tx_data(b_data), .tx_busy(tx_busy),
        .grant_id(b_grant), .busy(b_busy), .err_timeout(b_err)
    );

    // Transmitter model: sample at negedge, hold busy for three cycles after each start.
    always begin
        @(negedge clk);
        started = mon_start;
        if (mon_start) tx_log.push_back(mon_data);
        if (|mon_ready) rdy_log.push_back(mon_ready);
        @(posedge clk);
        #1;
        if (started) busy_cnt = 3;
        if (busy_cnt > 0) begin
            model_busy = 1'b1;
            busy_cnt--;
        end else begin
            model_busy = 1'b0;
        end
    end

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_grant;
        logic [7:0]  exp_tag;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int i);
        if (i < tx_log.size()) return tx_log[i];
        return 8'hxx;
    endfunction

    function automatic logic [3:0] rdy_at(input int i);
        if (i < rdy_log.size()) return rdy_log[i];
        return 4'hx;
    endfunction

    task automatic check_reset_vals(input string name);
        check({name, "_tx_start"}, mon_start, 1'b0);
        check({name, "_tx_data"}, mon_data, 8'h00);
        check({name, "_req_ready"}, mon_ready, 4'b0000);
        check({name, "_grant_id"}, mon_grant, 2'd0);
        check({name, "_busy"}, mon_busy, 1'b0);
        check({name, "_err"}, mon_err, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = '0;
        man_busy  = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tx_log.delete();
        rdy_log.delete();
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!mon_busy) break;
        end
        check(name, k < 200, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int wait_cnt;
        tbl[0] = '{4'b0100, 32'h0055_0000, 4'b0100, 2'd2, 8'hA2, 8'h55};
        tbl[1] = '{4'b1111, 32'h4433_2211, 4'b1000, 2'd3, 8'hA3, 8'h44};
        tbl[2] = '{4'b1111, 32'h4433_2211, 4'b0001, 2'd0, 8'hA0, 8'h11};
        tbl[3] = '{4'b0011, 32'h0000_BEEF, 4'b0010, 2'd1, 8'hA1, 8'hBE};
        tbl[4] = '{4'b0011, 32'h0000_BEEF, 4'b0001, 2'd0, 8'hA0, 8'hEF};
        tbl[5] = '{4'b1001, 32'hC300_005A, 4'b1000, 2'd3, 8'hA3, 8'hC3};
        tbl[6] = '{4'b0010, 32'h0000_7E00, 4'b0010, 2'd1, 8'hA1, 8'h7E};
        tbl[7] = '{4'b0101, 32'h00A5_000F, 4'b0100, 2'd2, 8'hA2, 8'hA5};
        tbl[8] = '{4'b0101, 32'h00A5_000F, 4'b0001, 2'd0, 8'hA0, 8'h0F};

        // Table: round-robin sequence of tagged frames from reset.
        sel_nt  = 1'b0;
        auto_tx = 1'b1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            tx_log.delete();
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), mon_ready, tbl[i].exp_ready);
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            check($sformatf("tbl%0d_ready_off", i), mon_ready, 4'b0000);
            check($sformatf("tbl%0d_grant", i), mon_grant, tbl[i].exp_grant);
            wait_idle($sformatf("tbl%0d_idle", i));
            check($sformatf("tbl%0d_nbytes", i), tx_log.size(), 2);
            check($sformatf("tbl%0d_tag", i), byte_at(0), tbl[i].exp_tag);
            check($sformatf("tbl%0d_byte", i), byte_at(1), tbl[i].exp_byte);
        end

        // All four continuously valid: grant order 0,1,2,3,0.
        do_reset();
        @(posedge clk); #1;
        req_valid = 4'hF;
        req_data  = 32'h4433_2211;
        wait_cnt  = 0;
        while (rdy_log.size() < 5 && wait_cnt < 400) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("rr_rounds_done", wait_cnt < 400, 1'b1);
        check("rr_g0", rdy_at(0), 4'b0001);
        check("rr_g1", rdy_at(1), 4'b0010);
        check("rr_g2", rdy_at(2), 4'b0100);
        check("rr_g3", rdy_at(3), 4'b1000);
        check("rr_g4", rdy_at(4), 4'b0001);
        check("rr_first_tag", byte_at(0), 8'hA0);
        check("rr_first_byte", byte_at(1), 8'h11);
        @(posedge clk); #1;
        req_valid = '0;

        // Busy timeout: transmitter never responds.
        auto_tx = 1'b0;
        do_reset();
        @(posedge clk); #1;
        req_valid = 4'b0001;
        req_data  = 32'h0000_00AB;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("to_tag_start", mon_start, 1'b1);
        check("to_tag_data", mon_data, 8'hA0);
        wait_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mon_err) break;
            wait_cnt++;
        end
        check("to_cycles", wait_cnt, 16);
        check("to_busy", mon_busy, 1'b0);
        check("to_nbytes", tx_log.size(), 1);
        repeat (3) @(negedge clk);
        check("to_sticky", mon_err, 1'b1);
        @(posedge clk); #1;
        req_valid = 4'hF;
        @(negedge clk);
        check("to_next_grant", mon_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;

        // Transmitter busy on SEND_DATA entry: start held off, then one pulse.
        do_reset();
        @(posedge clk); #1;
        req_valid = 4'b0010;
        req_data  = 32'h0000_9900;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        man_busy = 1'b1;
        @(posedge clk); #1;
        man_busy = 1'b0;
        @(posedge clk); #1;
        man_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold_start%0d", k), mon_start, 1'b0);
            @(posedge clk); #1;
        end
        man_busy = 1'b0;
        @(negedge clk);
        check("hold_release_start", mon_start, 1'b1);
        check("hold_release_data", mon_data, 8'h99);
        @(posedge clk); #1;
        man_busy = 1'b1;
        @(posedge clk); #1;
        man_busy = 1'b0;
        wait_idle("hold_idle");
        check("hold_nbytes", tx_log.size(), 2);
        check("hold_tag", byte_at(0), 8'hA1);
        check("hold_byte", byte_at(1), 8'h99);
        check("hold_err", mon_err, 1'b0);

        // Reset during WAIT_LO of the tag byte.
        do_reset();
        @(posedge clk); #1;
        req_valid = 4'b1000;
        req_data  = 32'h7700_0000;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        man_busy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_busy", mon_busy, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_mid");
        @(posedge clk); #1;
        rst_n    = 1'b1;
        man_busy = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_mid_nbytes", tx_log.size(), 1);
        @(posedge clk); #1;
        req_valid = 4'b1001;
        @(negedge clk);
        check("rst_mid_first_grant", mon_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;

        // Untagged instance: single data byte per frame.
        sel_nt  = 1'b1;
        auto_tx = 1'b1;
        do_reset();
        @(posedge clk); #1;
        req_valid = 4'b0010;
        req_data  = 32'h0000_3C00;
        @(negedge clk);
        check("nt_ready", mon_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("nt_grant", mon_grant, 2'd1);
        wait_idle("nt_idle");
        check("nt_nbytes", tx_log.size(), 1);
        check("nt_byte", byte_at(0), 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters; legal range 2..4.
REQ-002 SHALL have parameter TAG_EN, default 1; when 1, each byte is sent as a 2-byte frame (tag, data).
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 16, cycles allowed for tx_busy to rise after tx_start.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester byte pending.
REQ-007 SHALL have port req_data  input  8*N_REQ  byte of requester i in bits [8i+7:8i].
REQ-008 SHALL have port req_ready  output  N_REQ  one-hot acceptance strobe.
REQ-009 SHALL have port tx_start  output  1  start pulse to transmitter.
REQ-010 SHALL have port tx_data  output  8  byte to transmitter, registered.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy.
REQ-012 SHALL have port grant_id  output  2  index of requester currently owning the line.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port err_timeout  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement states IDLE, SEND_TAG, SEND_DATA, WAIT_HI, WAIT_LO.
REQ-016 In IDLE with any req_valid set, SHALL select winner round-robin, searching from (last_grant+1) mod N_REQ upward.
REQ-017 req_ready[winner] SHALL be high combinationally in that same IDLE cycle only; req_data[winner] captured on that edge; requester holds valid/data until ready.
REQ-018 On acceptance SHALL load grant_id and go to SEND_TAG if TAG_EN=1, else SEND_DATA.
REQ-019 Tag byte SHALL be {4'hA, 2'b00, grant_id}.
REQ-020 In SEND_TAG/SEND_DATA SHALL assert tx_start for exactly one cycle with tx_data valid, only when tx_busy=0; otherwise hold state, tx_start=0.
REQ-021 After tx_start SHALL enter WAIT_HI; leave to WAIT_LO when tx_busy=1.
REQ-022 WAIT_HI SHALL count cycles; on reaching BUSY_TIMEOUT without tx_busy, set err_timeout, discard frame, go IDLE, update last_grant.
REQ-023 WAIT_LO SHALL wait for tx_busy=0; then go SEND_DATA if tag phase just completed, else IDLE and set last_grant=grant_id.
REQ-024 Frames SHALL never interleave; new acceptance only from IDLE.
REQ-025 Single requester continuously valid SHALL be re-granted every frame; no idle-cycle penalty beyond one IDLE cycle.
REQ-026 req_ready SHALL be all-zero outside IDLE and when no req_valid set.
REQ-027 err_timeout SHALL stay set until rst_n asserted.
REQ-028 Timeout counter SHALL be width clog2(BUSY_TIMEOUT+1), cleared on WAIT_HI entry, saturating.

Reset
REQ-029 On rst_n low, SHALL immediately force IDLE, tx_start=0, tx_data=8'h00, req_ready=0, grant_id=0, busy=0, err_timeout=0, last_grant=N_REQ-1.
REQ-030 Reset mid-frame SHALL abandon the frame with no further tx_start; first grant after reset goes to requester 0.

Structure
REQ-031 Shared package uart_arb_pkg SHALL hold the state enum, TAG_NIBBLE=4'hA and grant-index width.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (req vector, last_grant in; one-hot grant, index out, combinational).

Verification
REQ-033 TAG_EN=1, req 2 valid with 8'h55 -> req_ready=4'b0100 one cycle; tx bytes 8'hA2 then 8'h55, one tx_start each.
REQ-034 All four valid continuously after reset -> grant order 0,1,2,3,0; each req_ready exactly once per round.
REQ-035 tx_busy held 0 after tx_start, BUSY_TIMEOUT=16 -> err_timeout set 16 cycles after WAIT_HI entry, return IDLE, no data byte.
REQ-036 tx_busy=1 when SEND_DATA entered -> tx_start withheld until tx_busy=0, then single pulse.
REQ-037 rst_n low during WAIT_LO of tag byte -> outputs at reset values next cycle, no data byte sent.
REQ-038 TAG_EN=0, req 1 valid 8'h3C -> one tx_start with tx_data=8'h3C, grant_id=1.
